io_timer_bank: RTL and testbench
================================

Name: io_timer_bank

Overview:
- Memory-mapped bank of NCH independent down-counting timers, each suitable as a 24-second shot clock. Sits in the CPU I/O window (BASE..BASE+0xFF) beside RAM.
- Driven by the CPU bus `adr`, `writedata` and `memwrite`; returns `io_data` to the top-level memdata mux.
- A shared prescaler generates the count tick. Each channel supports run/stop, software load, auto-reload, an expiry flag and an interrupt.

Parameters:
- WIDTH, 32: bus data/address width.
- NCH, 4: number of timer channels, 1..15.
- CNTW, 8: counter width per channel.
- PRESCALE, 100000000: clk cycles per count tick (1 s at 100 MHz); must be >= 1.
- BASE, 32'h0000FF00: base address of the I/O window.
- RESET_LOAD, 24: reset value of every LOAD and COUNT register.

Ports:
- `clk`, input, 1: system clock, all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `adr`, input, WIDTH: CPU byte address.
- `writedata`, input, WIDTH: CPU write data.
- `memwrite`, input, 1: write strobe, one-cycle qualified.
- `io_data`, output, WIDTH: read data, combinational on `adr`.
- `expired`, output, NCH: per-channel expiry flags, a direct register view.
- `irq`, output, 1: OR over channels of (expired & CTRL.IE).

Behaviour:
- Decode: the block is selected when `adr[WIDTH-1:8]` == `BASE[WIDTH-1:8]`; `adr[1:0]` is ignored.
- Channel c occupies BASE+16*c:
  - +0 CTRL (R/W): bit0 RUN, bit1 AUTORELOAD, bit2 IE, bit3 LOADNOW. LOADNOW is write-only, self-clearing and reads 0.
  - +4 LOAD (R/W): bits[CNTW-1:0].
  - +8 COUNT (RO).
  - +C STATUS: bit0 EXPIRED, write-1-to-clear.
- Global registers:
  - BASE+0xF0 IRQSTAT (RO): bits[NCH-1:0] = expired & IE.
  - BASE+0xF4 START (WO): each set bit c copies LOAD into COUNT and sets RUN for channel c; all selected channels start in the same cycle.
- Unused, out-of-range and channel >= NCH addresses read 0; writes to them are ignored.
- Reads have zero latency: `io_data` is valid in the same cycle as `adr`. Writes take effect at the clock edge where `memwrite` = 1. Unused upper bits read 0.
- Reset (asynchronous):
  - CTRL = 0, LOAD = COUNT = RESET_LOAD, EXPIRED = 0, prescaler = 0.
  - `io_data` shows register reset values; `expired` = 0, `irq` = 0.
  - A reset arriving mid-count aborts all channels immediately.
- Prescaler: free-running from 0 to PRESCALE-1. `tick` = 1 for exactly one cycle when the prescaler equals PRESCALE-1. The prescaler is never stopped or reset by register writes.
- Channel FSM states are IDLE (RUN = 0) and RUN (RUN = 1). EXPIRED is a separate sticky flag.
  - RUN with tick and COUNT > 1: COUNT -= 1.
  - RUN with tick and COUNT == 1: COUNT = 0 and EXPIRED = 1. If AUTORELOAD, COUNT = LOAD and the channel stays in RUN. Otherwise RUN = 0, giving IDLE.
  - RUN with tick and COUNT == 0 (e.g. started with LOAD = 0): EXPIRED = 1 with no decrement, then reload or stop as above. COUNT never wraps below 0.
  - IDLE: COUNT holds its value; ticks are ignored.
- Write precedence in the same cycle:
  - A CPU write (LOADNOW, START or CTRL.RUN) beats the tick update: COUNT takes the loaded value and that tick is not applied.
  - EXPIRED set beats a W1C clear.
  - LOADNOW together with RUN = 1 in one CTRL write loads, then runs from the next tick.
- Writing CTRL.RUN = 0 pauses the channel; COUNT holds. Writing RUN = 1 resumes from the held COUNT.
- Width rules: LOAD and COUNT writes take `writedata[CNTW-1:0]`; reads zero-extend to WIDTH.

Decomposition:
- Package io_timer_pkg holds:
  - register offsets CTRL_OFS = 0x0, LOAD_OFS = 0x4, COUNT_OFS = 0x8, STAT_OFS = 0xC, IRQSTAT_OFS = 0xF0, START_OFS = 0xF4;
  - CTRL bit indices RUN = 0, AUTORELOAD = 1, IE = 2, LOADNOW = 3;
  - CH_STRIDE = 16.
- One sub-module, io_timer_channel, is instantiated NCH times. It holds CTRL, LOAD, COUNT and EXPIRED and takes tick, write strobes and writedata.
- The top level contains the prescaler, address decode, read mux and irq OR.

Test Plan (PRESCALE = 4, NCH = 4, CNTW = 8):
- Reset: read BASE+8 -> 24, BASE+0xC -> 0; `irq` = 0. Assert `reset` asynchronously between edges mid-count -> COUNT returns to 24 and RUN = 0 immediately.
- One-shot: write LOAD0 = 3, then CTRL0 = 0xD (RUN | IE | LOADNOW). Expect COUNT 3->2->1->0 on successive ticks, 4 clk apart. EXPIRED0 = 1, `irq` = 1, RUN = 0, and COUNT stays 0 after further ticks.
- Auto-reload: LOAD1 = 2, CTRL1 = 0xB. Expect sequence 2, 1, then expire with COUNT = 2 reloaded. Expiry repeats every 2 ticks and RUN stays 1.
- W1C race: write 1 to STATUS0 in the same cycle as a new expiry -> EXPIRED0 remains 1. Write 1 to STATUS0 with no expiry -> 0 and `irq` drops.
- START with pause: write LOAD2 = 5, LOAD3 = 7, then START = 0xC -> both channels begin on the same edge. Write CTRL2 RUN = 0 at COUNT = 3 -> COUNT2 holds 3 over 3 ticks. Set RUN = 1 again -> 2.
- Decode: read BASE+0x40 (channel 4) -> 0. Writes there, or to `adr` 0x5, leave all registers unchanged. IRQSTAT reads exactly expired & IE.

Source files
------------

// File: rtl/io_timer_pkg.sv
// Shared register map, control-bit indices and channel state type for the
// memory-mapped timer bank.
package io_timer_pkg;

    localparam logic [7:0] CTRL_OFS    = 8'h00;
    localparam logic [7:0] LOAD_OFS    = 8'h04;
    localparam logic [7:0] COUNT_OFS   = 8'h08;
    localparam logic [7:0] STAT_OFS    = 8'h0C;
    localparam logic [7:0] IRQSTAT_OFS = 8'hF0;
    localparam logic [7:0] START_OFS   = 8'hF4;

    localparam int unsigned RUN        = 0;
    localparam int unsigned AUTORELOAD = 1;
    localparam int unsigned IE         = 2;
    localparam int unsigned LOADNOW    = 3;

    localparam int unsigned CH_STRIDE  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/io_timer_channel.sv
// One down-counting timer: CTRL, LOAD, COUNT and the sticky EXPIRED flag.
// CPU writes to COUNT/RUN take priority over the tick in the same cycle.
module io_timer_channel
    import io_timer_pkg::*;
#(
    parameter int unsigned CNTW       = 8,
    parameter int unsigned RESET_LOAD = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            ctrl_we,
    input  logic [3:0]      ctrl_wdata,
    input  logic            load_we,
    input  logic [CNTW-1:0] load_wdata,
    input  logic            stat_clr,
    input  logic            start,
    output logic            run,
    output logic            autoreload,
    output logic            ie,
    output logic [CNTW-1:0] load,
    output logic [CNTW-1:0] count,
    output logic            expired
);

    chan_state_e state;

    assign run = (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            autoreload <= 1'b0;
            ie         <= 1'b0;
            load       <= CNTW'(RESET_LOAD);
            count      <= CNTW'(RESET_LOAD);
            expired    <= 1'b0;
        end else begin
            if (load_we) begin
                load <= load_wdata;
            end
            // A clear is overridden below when the same edge sets EXPIRED
            if (stat_clr) begin
                expired <= 1'b0;
            end
            if (start) begin
                count <= load;
                state <= ST_RUN;
            end else if (ctrl_we) begin
                autoreload <= ctrl_wdata[AUTORELOAD];
                ie         <= ctrl_wdata[IE];
                state      <= ctrl_wdata[RUN] ? ST_RUN : ST_IDLE;
                if (ctrl_wdata[LOADNOW]) begin
                    count <= load;
                end
            end else if (tick) begin
                case (state)
                    ST_RUN: begin
                        if (count > CNTW'(1)) begin
                            count <= count - CNTW'(1);
                        end else begin
                            expired <= 1'b1;
                            if (autoreload) begin
                                count <= load;
                            end else begin
                                count <= '0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/io_timer_bank.sv
// Memory-mapped bank of NCH down-counting timers sharing one prescaler.
// Reads are combinational on adr; writes land on the memwrite edge.
module io_timer_bank
    import io_timer_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      NCH        = 4,
    parameter int unsigned      CNTW       = 8,
    parameter int unsigned      PRESCALE   = 100000000,
    parameter logic [WIDTH-1:0] BASE       = 32'h0000FF00,
    parameter int unsigned      RESET_LOAD = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             memwrite,
    output logic [WIDTH-1:0] io_data,
    output logic [NCH-1:0]   expired,
    output logic             irq
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]   presc;
    logic            tick;
    logic            sel;
    logic            glb;
    logic [3:0]      ch;
    logic [7:0]      ch_ofs;
    logic [7:0]      glb_ofs;
    logic            start_we;
    logic [NCH-1:0]  run_v;
    logic [NCH-1:0]  ar_v;
    logic [NCH-1:0]  ie_v;
    logic [NCH-1:0]  exp_v;
    logic [NCH-1:0]  irq_v;
    logic [CNTW-1:0] load_a  [NCH];
    logic [CNTW-1:0] count_a [NCH];
    logic            unused_bits;

    // Free-running prescaler; register writes never touch it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (presc == PW'(PRESCALE - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = (presc == PW'(PRESCALE - 1));

    // Address decode; adr[1:0] is ignored and channel index 15 is the global page
    assign sel      = (adr[WIDTH-1:8] == BASE[WIDTH-1:8]);
    assign ch       = 4'(adr[7:0] / 8'(CH_STRIDE));
    assign ch_ofs   = {4'h0, adr[3:2], 2'b00};
    assign glb_ofs  = {adr[7:2], 2'b00};
    assign glb      = (ch == 4'hF);
    assign start_we = memwrite && sel && glb && (glb_ofs == START_OFS);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic hit;
        assign hit = memwrite && sel && (ch == 4'(c));

        io_timer_channel #(
            .CNTW       (CNTW),
            .RESET_LOAD (RESET_LOAD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .ctrl_we    (hit && (ch_ofs == CTRL_OFS)),
            .ctrl_wdata (writedata[3:0]),
            .load_we    (hit && (ch_ofs == LOAD_OFS)),
            .load_wdata (writedata[CNTW-1:0]),
            .stat_clr   (hit && (ch_ofs == STAT_OFS) && writedata[0]),
            .start      (start_we && writedata[c]),
            .run        (run_v[c]),
            .autoreload (ar_v[c]),
            .ie         (ie_v[c]),
            .load       (load_a[c]),
            .count      (count_a[c]),
            .expired    (exp_v[c])
        );
    end

    assign irq_v   = exp_v & ie_v;
    assign irq     = |irq_v;
    assign expired = exp_v;

    // Zero-latency read mux; anything not decoded reads 0
    always_comb begin
        io_data = '0;
        if (sel) begin
            if (glb) begin
                if (glb_ofs == IRQSTAT_OFS) begin
                    io_data = WIDTH'(irq_v);
                end
            end else begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    if (ch == 4'(c)) begin
                        case (ch_ofs)
                            CTRL_OFS: begin
                                io_data[RUN]        = run_v[c];
                                io_data[AUTORELOAD] = ar_v[c];
                                io_data[IE]         = ie_v[c];
                            end
                            LOAD_OFS:  io_data = WIDTH'(load_a[c]);
                            COUNT_OFS: io_data = WIDTH'(count_a[c]);
                            STAT_OFS:  io_data = WIDTH'(exp_v[c]);
                            default:   io_data = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign unused_bits = ^{adr[1:0], writedata};

endmodule

// File: tb/tb_io_timer_bank.sv
// Randomised and directed bench for io_timer_bank against a register-level
// reference model of the timer bank.
`timescale 1ns/1ps
module tb_io_timer_bank;

    localparam int NCH      = 4;
    localparam int CNTW     = 8;
    localparam int PRESCALE = 4;
    localparam logic [31:0] BASE = 32'h0000FF00;
    localparam logic [31:0] IDLE_ADR = 32'h0000FFFC;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    adr = '0;
    logic [31:0]    writedata = '0;
    logic           memwrite = 1'b0;
    logic [31:0]    io_data;
    logic [NCH-1:0] expired;
    logic           irq;

    io_timer_bank #(
        .WIDTH(32), .NCH(NCH), .CNTW(CNTW), .PRESCALE(PRESCALE),
        .BASE(BASE), .RESET_LOAD(24)
    ) dut (
        .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
        .memwrite(memwrite), .io_data(io_data), .expired(expired), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit m_run [NCH];
    bit m_ar  [NCH];
    bit m_ie  [NCH];
    bit m_exp [NCH];
    int m_load[NCH];
    int m_cnt [NCH];
    int m_pre;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_ar[c] = 0; m_ie[c] = 0; m_exp[c] = 0;
            m_load[c] = 24; m_cnt[c] = 24;
        end
        m_pre = 0;
    endfunction

    // One clock edge of the bank as seen by software
    function automatic void model_edge(bit we, logic [31:0] a, logic [31:0] d);
        bit tk, sel, wr, wctrl, wload, wstat, wstart;
        int off, ch, r;
        tk  = (m_pre == PRESCALE - 1);
        sel = (a[31:8] == BASE[31:8]);
        off = int'(a[7:0]);
        ch  = off / 16;
        r   = (off % 16) / 4;
        for (int c = 0; c < NCH; c++) begin
            wr     = we && sel && (ch == c);
            wctrl  = wr && (r == 0);
            wload  = wr && (r == 1);
            wstat  = wr && (r == 3) && d[0];
            wstart = we && sel && (off >= 'hF4) && (off <= 'hF7) && d[c];
            if (wload) m_load[c] = int'(d[7:0]);
            if (wstat) m_exp[c] = 0;
            if (wstart) begin
                m_cnt[c] = m_load[c];
                m_run[c] = 1;
            end else if (wctrl) begin
                m_run[c] = d[0]; m_ar[c] = d[1]; m_ie[c] = d[2];
                if (d[3]) m_cnt[c] = m_load[c];
            end else if (tk && m_run[c]) begin
                if (m_cnt[c] > 1) begin
                    m_cnt[c] = m_cnt[c] - 1;
                end else begin
                    m_exp[c] = 1;
                    if (m_ar[c]) m_cnt[c] = m_load[c];
                    else begin m_cnt[c] = 0; m_run[c] = 0; end
                end
            end
        end
        m_pre = (m_pre + 1) % PRESCALE;
    endfunction

    function automatic logic [NCH-1:0] m_expv();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_exp[c];
        return v;
    endfunction

    function automatic logic m_irq();
        logic v;
        v = 0;
        for (int c = 0; c < NCH; c++) v = v | (m_exp[c] & m_ie[c]);
        return v;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] v;
        int off, ch, r;
        v   = '0;
        off = int'(a[7:0]);
        ch  = off / 16;
        r   = (off % 16) / 4;
        if (a[31:8] != BASE[31:8]) return '0;
        if (ch == 15) begin
            if (r == 0) for (int c = 0; c < NCH; c++) v[c] = m_exp[c] & m_ie[c];
            return v;
        end
        if (ch >= NCH) return '0;
        case (r)
            0:       v = {29'd0, m_ie[ch], m_ar[ch], m_run[ch]};
            1:       v = 32'(m_load[ch]);
            2:       v = 32'(m_cnt[ch]);
            default: v = {31'd0, m_exp[ch]};
        endcase
        return v;
    endfunction

    // Drive one bus cycle, let the edge happen, advance the model with it
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d);
        adr = a; writedata = d; memwrite = we;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        adr = BASE + 32'h8; #1;
        n_cmp++; if (io_data !== 32'd24) begin n_err++; $display("FAIL reset_count: got %0d want 24", io_data); end
        adr = BASE + 32'hC; #1;
        n_cmp++; if (io_data !== 32'd0) begin n_err++; $display("FAIL reset_status: got %0h want 0", io_data); end
        n_cmp++; if (irq !== 1'b0 || expired !== 4'h0) begin n_err++; $display("FAIL reset_irq: got irq=%b exp=%b want 0/0000", irq, expired); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_one_shot();
        step(1, BASE + 32'h4, 32'd3);
        step(1, BASE + 32'h0, 32'hD);
        for (int i = 0; i < 24; i++) begin
            step(0, BASE + 32'h8, 0);
            n_cmp++; if (io_data !== model_read(adr) || expired !== m_expv() || irq !== m_irq()) begin
                n_err++; $display("FAIL one_shot[%0d]: got cnt=%0d exp=%b irq=%b want cnt=%0d exp=%b irq=%b",
                                  i, io_data, expired, irq, model_read(adr), m_expv(), m_irq());
            end
        end
        n_cmp++; if (io_data !== 32'd0 || expired[0] !== 1'b1 || irq !== 1'b1) begin
            n_err++; $display("FAIL one_shot_end: got cnt=%0d exp0=%b irq=%b want 0/1/1", io_data, expired[0], irq);
        end
        adr = BASE; #1;
        n_cmp++; if (io_data !== 32'h4) begin n_err++; $display("FAIL one_shot_ctrl: got %0h want 4", io_data); end
    endtask

    task automatic test_autoreload();
        step(1, BASE + 32'h14, 32'd2);
        step(1, BASE + 32'h10, 32'hB);
        for (int i = 0; i < 24; i++) begin
            step(0, BASE + 32'h18, 0);
            n_cmp++; if (io_data !== model_read(adr) || expired !== m_expv()) begin
                n_err++; $display("FAIL autoreload[%0d]: got cnt=%0d exp=%b want cnt=%0d exp=%b",
                                  i, io_data, expired, model_read(adr), m_expv());
            end
        end
        adr = BASE + 32'h10; #1;
        n_cmp++; if (io_data !== 32'h3 || expired[1] !== 1'b1) begin
            n_err++; $display("FAIL autoreload_ctrl: got ctrl=%0h exp1=%b want 3/1", io_data, expired[1]);
        end
    endtask

    task automatic test_w1c_race();
        int guard;
        step(1, BASE + 32'h4, 32'd2);
        step(1, BASE + 32'h0, 32'hF);
        step(1, BASE + 32'hC, 32'd1);
        n_cmp++; if (expired[0] !== 1'b0) begin n_err++; $display("FAIL w1c_plain: got %b want 0", expired[0]); end
        guard = 0;
        while (!(m_pre == PRESCALE - 1 && m_run[0] && m_cnt[0] <= 1) && guard < 40) begin
            step(0, IDLE_ADR, 0);
            guard++;
        end
        if (guard >= 40) begin n_cmp++; n_err++; $display("FAIL w1c_timeout: got %0d cycles want <40", guard); end
        step(1, BASE + 32'hC, 32'd1);
        n_cmp++; if (expired[0] !== 1'b1 || irq !== 1'b1) begin
            n_err++; $display("FAIL w1c_race: got exp0=%b irq=%b want 1/1", expired[0], irq);
        end
        step(1, BASE + 32'h0, 32'h4);
        step(1, BASE + 32'hC, 32'd1);
        n_cmp++; if (expired[0] !== 1'b0 || irq !== 1'b0) begin
            n_err++; $display("FAIL w1c_clear: got exp0=%b irq=%b want 0/0", expired[0], irq);
        end
    endtask

    task automatic test_start_pause();
        int guard;
        step(1, BASE + 32'h24, 32'd5);
        step(1, BASE + 32'h34, 32'd7);
        step(1, BASE + 32'hF4, 32'hC);
        adr = BASE + 32'h28; #1;
        n_cmp++; if (io_data !== 32'd5) begin n_err++; $display("FAIL start_cnt2: got %0d want 5", io_data); end
        adr = BASE + 32'h38; #1;
        n_cmp++; if (io_data !== 32'd7) begin n_err++; $display("FAIL start_cnt3: got %0d want 7", io_data); end
        guard = 0;
        while (m_cnt[2] != 3 && guard < 40) begin step(0, IDLE_ADR, 0); guard++; end
        if (guard >= 40) begin n_cmp++; n_err++; $display("FAIL pause_timeout: got %0d cycles want <40", guard); end
        step(1, BASE + 32'h20, 32'h0);
        repeat (12) step(0, BASE + 32'h28, 0);
        n_cmp++; if (io_data !== 32'd3) begin n_err++; $display("FAIL pause_hold: got %0d want 3", io_data); end
        step(1, BASE + 32'h20, 32'h1);
        repeat (4) step(0, BASE + 32'h28, 0);
        n_cmp++; if (io_data !== 32'd2 || io_data !== model_read(adr)) begin
            n_err++; $display("FAIL resume: got %0d want 2", io_data);
        end
    endtask

    task automatic test_decode();
        step(0, BASE + 32'h40, 0);
        n_cmp++; if (io_data !== 32'd0) begin n_err++; $display("FAIL decode_ch4: got %0h want 0", io_data); end
        step(1, BASE + 32'h40, 32'hFF);
        step(1, BASE + 32'h44, 32'h55);
        step(1, 32'h5, 32'hF);
        step(1, 32'h4, 32'h11);
        step(1, BASE + 32'hF8, 32'hF);
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                step(0, BASE + 32'(c * 16 + r * 4), 0);
                n_cmp++; if (io_data !== model_read(adr)) begin
                    n_err++; $display("FAIL decode_reg[%0d.%0d]: got %0h want %0h", c, r, io_data, model_read(adr));
                end
            end
        end
        step(0, BASE + 32'hF0, 0);
        n_cmp++; if (io_data !== 32'(m_expv() & {m_ie[3], m_ie[2], m_ie[1], m_ie[0]})) begin
            n_err++; $display("FAIL irqstat: got %0h want %0h", io_data, model_read(adr));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        int ch, r;
        for (int i = 0; i < 400; i++) begin
            ch = $urandom_range(0, 4);
            r  = $urandom_range(0, 3);
            a  = (ch == 4) ? BASE + 32'hF0 + 32'(r * 4) : BASE + 32'(ch * 16 + r * 4);
            a  = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            d  = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 6));
            if ($urandom_range(0, 4) == 0) step(1, a, d);
            else step(0, a, 0);
            n_cmp++; if (io_data !== model_read(a) || expired !== m_expv() || irq !== m_irq()) begin
                n_err++; $display("FAIL random[%0d] adr=%0h: got %0h/%b/%b want %0h/%b/%b",
                                  i, a, io_data, expired, irq, model_read(a), m_expv(), m_irq());
            end
        end
    endtask

    task automatic test_reset_midcount();
        step(1, BASE + 32'hF4, 32'hF);
        repeat (5) step(0, BASE + 32'h8, 0);
        adr = BASE + 32'h8;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (io_data !== 32'd24 || expired !== 4'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got cnt=%0d exp=%b irq=%b want 24/0000/0", io_data, expired, irq);
        end
        for (int c = 0; c < NCH; c++) begin
            adr = BASE + 32'(c * 16); #1;
            n_cmp++; if (io_data !== 32'd0) begin n_err++; $display("FAIL reset_ctrl[%0d]: got %0h want 0", c, io_data); end
            adr = BASE + 32'(c * 16 + 8); #1;
            n_cmp++; if (io_data !== 32'd24) begin n_err++; $display("FAIL reset_cnt[%0d]: got %0d want 24", c, io_data); end
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (10) step(0, BASE + 32'h8, 0);
        n_cmp++; if (io_data !== 32'd24 || io_data !== model_read(adr)) begin
            n_err++; $display("FAIL post_reset_idle: got %0d want 24", io_data);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_autoreload();
        test_w1c_race();
        test_start_pause();
        test_decode();
        test_random();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t want completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
